// File: rtl/mux_sweep_checker.sv
// Sweep sequencer for a 2:1 mux stage: walks all 8 {S,B,A} vectors, samples Z
// after a settle window, and counts mismatches against Z = S ? B : A.
module mux_sweep_checker #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned HOLD   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       S,
    input  logic       Z,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       sample_valid,
    output logic       sample_Z,
    output logic [3:0] err_count,
    output logic       done,
    output logic       pass
);

    localparam int unsigned CMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int unsigned CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] HOLD_LD   = (HOLD == 0) ? '0 : CW'(HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    vec_q, vec_d;
    logic          sv_q, sv_d;
    logic          sz_q, sz_d;
    logic [3:0]    err_q, err_d;
    logic          pass_q, pass_d;
    logic          exp_z;

    assign exp_z = vec_q[2] ? vec_q[1] : vec_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            sv_q    <= 1'b0;
            sz_q    <= 1'b0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            sv_q    <= sv_d;
            sz_q    <= sz_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        sv_d    = 1'b0;
        sz_d    = sz_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    cnt_d   = SETTLE_LD;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SAMPLE: begin
                sz_d = Z;
                sv_d = 1'b1;
                if (Z != exp_z) err_d = err_q + 4'd1;
                // With no hold window the vector advance happens straight from SAMPLE.
                if (HOLD > 0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else if (vec_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = SETTLE_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (vec_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = SETTLE_LD;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign A            = vec_q[0];
    assign B            = vec_q[1];
    assign S            = vec_q[2];
    assign vec_idx      = vec_q;
    assign busy         = (state_q != ST_IDLE);
    assign sample_valid = sv_q;
    assign sample_Z     = sz_q;
    assign err_count    = err_q;
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: default-parameter instance plus a SETTLE=1/HOLD=0
// instance, each driving a behavioural mux model that can be made faulty.
module tb_mux_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   mode = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // mode: 0 correct, 1 stuck-at-0, 2 inverted, 3 swapped select
    function automatic logic mux_ref(input int md, input logic a, input logic b, input logic s);
        logic ideal;
        ideal = s ? b : a;
        case (md)
            1:       return 1'b0;
            2:       return ~ideal;
            3:       return s ? a : b;
            default: return ideal;
        endcase
    endfunction

    logic       start0, start1;
    logic       A0, B0, S0, Z0, busy0, sv0, sz0, done0, pass0;
    logic       A1, B1, S1, Z1, busy1, sv1, sz1, done1, pass1;
    logic [2:0] vec0, vec1;
    logic [3:0] err0, err1;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign Z0 = mux_ref(mode, A0, B0, S0);
    assign Z1 = mux_ref(mode, A1, B1, S1);

    mux_sweep_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(A0), .B(B0), .S(S0), .Z(Z0),
        .vec_idx(vec0), .busy(busy0), .sample_valid(sv0), .sample_Z(sz0),
        .err_count(err0), .done(done0), .pass(pass0)
    );

    mux_sweep_checker #(.SETTLE(1), .HOLD(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .S(S1), .Z(Z1),
        .vec_idx(vec1), .busy(busy1), .sample_valid(sv1), .sample_Z(sz1),
        .err_count(err1), .done(done1), .pass(pass1)
    );

    logic       o_A, o_B, o_S, o_busy, o_sv, o_sz, o_done, o_pass;
    logic [2:0] o_vec;
    logic [3:0] o_err;

    always_comb begin
        o_A    = (sel == 1) ? A1    : A0;
        o_B    = (sel == 1) ? B1    : B0;
        o_S    = (sel == 1) ? S1    : S0;
        o_busy = (sel == 1) ? busy1 : busy0;
        o_sv   = (sel == 1) ? sv1   : sv0;
        o_sz   = (sel == 1) ? sz1   : sz0;
        o_done = (sel == 1) ? done1 : done0;
        o_pass = (sel == 1) ? pass1 : pass0;
        o_vec  = (sel == 1) ? vec1  : vec0;
        o_err  = (sel == 1) ? err1  : err0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_vec"}, o_vec, 0);
        chk({tag, "_abs"}, {o_S, o_B, o_A}, 0);
        chk({tag, "_sv"}, o_sv, 0);
        chk({tag, "_sz"}, o_sz, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_pass"}, o_pass, 0);
    endtask

    // One sweep; observation k is taken 1 time unit after the k-th edge past the start edge.
    task automatic run_sweep(input int sel_i, input int md, input bit glitch, input bit keep);
        int set_c, hld_c, p, n, errs, v, exp_vec, tot;
        logic exp_sv, ez, ideal;
        int totals[4] = '{0, 4, 8, 4};
        sel   = sel_i;
        mode  = md;
        set_c = 1;
        hld_c = (sel_i == 1) ? 0 : 10;
        p     = set_c + 1 + hld_c;
        n     = 8 * p;
        errs  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_vec", o_vec, 0);
        chk("start_err", o_err, 0);
        chk("start_pass", o_pass, 0);
        for (int k = 1; k <= n + 1; k++) begin
            if (glitch && !keep) start = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            exp_sv = (k >= set_c + 1) && (((k - set_c - 1) % p) == 0) && (((k - set_c - 1) / p) < 8);
            chk("sample_valid", o_sv, exp_sv);
            chk("done", o_done, k == n);
            chk("busy", o_busy, k <= n);
            exp_vec = (k / p > 7) ? 7 : k / p;
            chk("vec_idx", o_vec, exp_vec);
            chk("abs_decode", {o_S, o_B, o_A}, exp_vec);
            if (exp_sv) begin
                v     = (k - set_c - 1) / p;
                ideal = v[2] ? v[1] : v[0];
                ez    = mux_ref(md, v[0], v[1], v[2]);
                if (ez != ideal) errs++;
                chk("sample_Z", o_sz, ez);
                chk("err_running", o_err, errs);
            end
        end
        tot = totals[md];
        chk("final_err", o_err, errs);
        chk("final_err_table", o_err, tot);
        chk("final_pass", o_pass, errs == 0);
    endtask

    initial begin
        bit found;
        #3;
        chk_all_zero("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("idle");

        run_sweep(0, 0, 0, 0);   // correct mux, defaults
        run_sweep(0, 1, 0, 0);   // stuck at 0
        run_sweep(0, 2, 0, 0);   // inverted
        run_sweep(0, 3, 0, 0);   // swapped select
        run_sweep(1, 0, 0, 0);   // SETTLE=1, HOLD=0
        run_sweep(1, 3, 0, 0);
        run_sweep(0, 0, 1, 0);   // start glitches while busy
        run_sweep(1, 2, 1, 0);
        run_sweep(0, 0, 0, 1);   // start held: back-to-back
        run_sweep(0, 1, 0, 1);
        run_sweep(0, 0, 0, 0);

        // Reset in the middle of vector 3
        sel = 0; mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_vec == 3'd3) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_vec3", found, 1);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", o_done, 0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("after_rst");
        run_sweep(0, 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            run_sweep(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
